// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared state type and default sizing for the debounce stage.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_t;

    localparam int DB_WIDTH  = 4;
    localparam int DB_CYCLES = 8;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : One channel: 2-flop synchroniser, mismatch counter, FSM and
//               registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DB_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw_in,
    output logic d_out,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               c_single = (DEBOUNCE_CYCLES == 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_d;
    logic             r_rise;
    logic             r_fall;

    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_d_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;
    logic             w_mismatch;

    assign w_mismatch = r_sync2 ^ r_d;

    // Synchroniser runs regardless of en so the sampled level is never stale.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_d     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_d     <= w_d_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_d_nxt     = r_d;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (en && w_mismatch) begin
                    if (c_single) begin
                        w_d_nxt    = r_sync2;
                        w_rise_nxt = r_sync2;
                        w_fall_nxt = ~r_sync2;
                    end else begin
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                // en low freezes everything, including bounce detection.
                if (en) begin
                    if (!w_mismatch) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else if (r_cnt == c_last) begin
                        w_d_nxt     = r_sync2;
                        w_rise_nxt  = r_sync2;
                        w_fall_nxt  = ~r_sync2;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_STABLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
    end

    assign d_out = r_d;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign busy  = (r_state == ST_COUNT);

endmodule : debounce_bit
`default_nettype wire

// File: rtl/debounce_sync4.sv
`default_nettype none
// ============================================================================
// Module      : debounce_sync4
// Description : WIDTH-channel synchronise-and-debounce stage feeding the
//               4-bit D register, with per-bit rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_sync4
    import debounce_pkg::*;
#(
    parameter int WIDTH           = DB_WIDTH,
    parameter int DEBOUNCE_CYCLES = DB_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0] w_busy;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("debounce_sync4: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .raw_in (raw_in[gi]),
            .d_out  (d_out[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi]),
            .busy   (w_busy[gi])
        );
    end

    assign stable = ~|w_busy;

endmodule : debounce_sync4
`default_nettype wire

// File: tb/tb_debounce_sync4.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_sync4
// Description : Scoreboard bench for debounce_sync4 with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_sync4;

    localparam int W = 4;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] raw_in;
    logic [W-1:0] d_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         stable;

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] r;
        logic [W-1:0] f;
        logic         st;
    } exp_t;

    exp_t q[$];
    exp_t mon_x;
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: two-stage sampled history, accepted level, and the number
    // of consecutive enabled cycles the sampled level has disagreed with it.
    logic [W-1:0] m_s1, m_s2, m_d;
    int           m_run[W];

    debounce_sync4 #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .raw_in (raw_in),
        .d_out  (d_out),
        .rise   (rise),
        .fall   (fall),
        .stable (stable)
    );

    always #10 clk = ~clk;

    task automatic model_step(input logic [W-1:0] r, input logic e, input logic rn);
        exp_t x;
        x.r = '0;
        x.f = '0;
        if (!rn) begin
            m_s1 = '0;
            m_s2 = '0;
            m_d  = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (e) begin
                    if (m_s2[i] != m_d[i]) begin
                        m_run[i]++;
                        if (m_run[i] >= N) begin
                            m_d[i] = m_s2[i];
                            if (m_s2[i]) x.r[i] = 1'b1;
                            else         x.f[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = r;
        end
        x.d  = m_d;
        x.st = 1'b1;
        for (int i = 0; i < W; i++) if (m_run[i] != 0) x.st = 1'b0;
        q.push_back(x);
    endtask

    // One clock of stimulus; the expectation for the coming edge is queued.
    task automatic drive(input logic [W-1:0] r, input logic e, input logic rn);
        @(negedge clk);
        raw_in = r;
        en     = e;
        rst_n  = rn;
        model_step(r, e, rn);
    endtask

    task automatic hold(input logic [W-1:0] r, input logic e, input int cycles);
        for (int k = 0; k < cycles; k++) drive(r, e, 1'b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_x = q.pop_front();
            n_vec++;
            if (d_out !== mon_x.d || rise !== mon_x.r || fall !== mon_x.f || stable !== mon_x.st) begin
                n_err++;
                $display("FAIL outputs t=%0t got d=%h rise=%h fall=%h stable=%b, want d=%h rise=%h fall=%h stable=%b",
                         $time, d_out, rise, fall, stable, mon_x.d, mon_x.r, mon_x.f, mon_x.st);
            end
        end
    end

    task automatic check_async_reset(input string name);
        #1;
        n_vec++;
        if (d_out !== '0 || rise !== '0 || fall !== '0 || stable !== 1'b1) begin
            n_err++;
            $display("FAIL %s got d=%h rise=%h fall=%h stable=%b, want d=0 rise=0 fall=0 stable=1",
                     name, d_out, rise, fall, stable);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rv;
        logic         ev;
        raw_in = 4'hF;
        en     = 1'b1;
        rst_n  = 1'b0;
        m_s1 = '0; m_s2 = '0; m_d = '0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
        check_async_reset("reset_at_start");

        // Reset held with inputs high
        for (int k = 0; k < 3; k++) drive(4'hF, 1'b1, 1'b0);
        drive(4'h0, 1'b1, 1'b1);
        hold(4'h0, 1'b1, 3);

        // Clean step on bit 0
        hold(4'b0001, 1'b1, 14);

        // Bounce on bit 1
        hold(4'b0011, 1'b1, 5);
        hold(4'b0001, 1'b1, 1);
        hold(4'b0011, 1'b1, 14);

        // All high, then release all together
        hold(4'hF, 1'b1, 14);
        hold(4'h0, 1'b1, 14);

        // Enable freeze mid-count
        hold(4'h5, 1'b1, 5);
        hold(4'h5, 1'b0, 4);
        hold(4'h5, 1'b1, 12);

        // Reset mid-count, then full latency again
        hold(4'hA, 1'b1, 7);
        @(negedge clk);
        rst_n = 1'b0;
        check_async_reset("reset_mid_count");
        model_step(4'hA, 1'b1, 1'b0);
        drive(4'hA, 1'b1, 1'b0);
        hold(4'hA, 1'b1, 14);

        // Randomised traffic with varying bounce density
        rv = 4'hA;
        for (int k = 0; k < 1500; k++) begin
            int p;
            p = (k / 250) % 2 == 0 ? 14 : 4;
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, p - 1) == 0) rv[i] = ~rv[i];
            ev = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) drive(rv, ev, 1'b0);
            else                             drive(rv, ev, 1'b1);
        end
        hold(rv, 1'b1, 14);

        for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_debounce_sync4
`default_nettype wire
